// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 16;

    // Helpers are sized for the largest supported N (16); callers slice.
    function automatic logic [15:0] to_onehot(input logic [3:0] idx);
        return 16'b1 << idx;
    endfunction

    function automatic logic [3:0] to_index(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) idx = idx | 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr, take lowest set bit, rotate back.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(DEF_N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] win,
    output logic           vld
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   lsb;
    logic [3:0]     idx_full;
    logic [IDW-1:0] idx;
    logic [IDW:0]   sum;

    always_comb begin
        dbl      = {req, req} >> ptr;
        rot      = dbl[N-1:0];
        lsb      = rot & (~rot + 1'b1);
        idx_full = to_index(16'(lsb));
        idx      = idx_full[IDW-1:0];
        // Undo the rotation modulo N; N need not be a power of two.
        sum      = {1'b0, idx} + {1'b0, ptr};
        if (sum >= (IDW+1)'(N))
            sum = sum - (IDW+1)'(N);
        win      = sum[IDW-1:0];
        vld      = |req;
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter whose grant is locked until DONE, request drop or hold timeout.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   REQ,
    input  logic           DONE,
    output logic [N-1:0]   GNT,
    output logic [IDW-1:0] GNT_ID,
    output logic           BUSY,
    output logic           TIMEOUT
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HW-1:0]  hold_cnt;
    logic [IDW-1:0] win;
    logic           win_vld;
    logic [15:0]    win_oh_full;
    logic [N-1:0]   win_oh;
    logic [IDW-1:0] ptr_nxt;
    logic           rel_done, rel_drop, rel_hold;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (REQ),
        .ptr (ptr),
        .win (win),
        .vld (win_vld)
    );

    // GNT_ID is registered with the grant, so it names the owner throughout GRANT.
    always_comb begin
        win_oh_full = to_onehot(4'(win));
        win_oh      = win_oh_full[N-1:0];
        ptr_nxt     = (GNT_ID == IDW'(N-1)) ? '0 : GNT_ID + 1'b1;
        rel_done    = DONE;
        rel_drop    = !REQ[GNT_ID];
        rel_hold    = (hold_cnt == HW'(MAX_HOLD));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            GNT      <= '0;
            GNT_ID   <= '0;
            BUSY     <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (win_vld) begin
                        GNT      <= win_oh;
                        GNT_ID   <= win;
                        BUSY     <= 1'b1;
                        hold_cnt <= HW'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_done || rel_drop || rel_hold) begin
                        GNT      <= '0;
                        GNT_ID   <= '0;
                        BUSY     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= ptr_nxt;
                        TIMEOUT  <= rel_hold && !rel_done && !rel_drop;
                        state    <= IDLE;
                    end else if (!rel_hold) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
